// File: rtl/de1_switch_debouncer.sv
// ============================================================================
// de1_switch_debouncer
//
// Conditions the raw DE1 slide switches before they reach the switcher PIO
// input of the de1_blinker Qsys system. Every channel is synchronised into
// clk_clk and then filtered by its own stability counter. A channel's clean
// level only changes after the synchronised input has disagreed with it for
// STABLE_CYCLES consecutive clocks. Any agreeing sample restarts the window.
//
// Parameters
//   WIDTH          number of switch channels
//   SYNC_STAGES    synchronizer depth (>= 2)
//   STABLE_CYCLES  consecutive differing samples needed to accept a level (>= 2)
//   RESET_VAL      sw_debounced value during and after reset
//
// Ports
//   clk_clk        in   system clock (50 MHz)
//   reset_reset_n  in   asynchronous active-low reset
//   sw_raw         in   raw switch pins, asynchronous to clk_clk
//   sw_debounced   out  clean levels, to switcher_external_connection_export
//   sw_rise        out  one-cycle pulse per channel on a 0->1 clean change
//   sw_fall        out  one-cycle pulse per channel on a 1->0 clean change
//
// Build option
//   SW_EDGE_PULSE_EN  when defined, sw_rise/sw_fall are registered edge
//                     pulses; otherwise both are tied low and no edge
//                     registers exist (ports are kept for a stable top level).
// ============================================================================
module de1_switch_debouncer #(
    parameter int unsigned      WIDTH         = 4,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter int unsigned      STABLE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int unsigned   CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Synchronizer: stage 0 captures the pins, the top stage feeds the filter.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef SW_EDGE_PULSE_EN
    logic [WIDTH-1:0] deb_next;
`endif

    // Per-channel stability filter.
    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          deb_q;
        logic          deb_d;

        // The update fires on the STABLE_CYCLES-th differing sample, so the
        // counter clears before it could ever reach STABLE_CYCLES.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (s[ch] != deb_q) begin
                if (cnt_q == CNT_LAST) begin
                    deb_d = s[ch];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                cnt_q <= '0;
                deb_q <= RESET_VAL[ch];
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign sw_debounced[ch] = deb_q;
`ifdef SW_EDGE_PULSE_EN
        assign deb_next[ch] = deb_d;
`endif
    end

`ifdef SW_EDGE_PULSE_EN
    // Registered alongside sw_debounced, so a pulse occupies exactly the
    // cycle in which the new clean level is first visible.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_rise <= '0;
            sw_fall <= '0;
        end else begin
            sw_rise <= deb_next & ~sw_debounced;
            sw_fall <= ~deb_next & sw_debounced;
        end
    end
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif

endmodule
